// File: rtl/mole_grid_renderer_if.sv
// Pixel-timing, mole-mask, strike and VGA colour signals of mole_grid_renderer.
// CURSOR_IDX exists only when MOLE_CURSOR_EN is defined.
interface mole_grid_renderer_if #(
    parameter int unsigned N     = 9,
    parameter int unsigned IDX_W = 4
);
    logic             PIX_STB;
    logic             FRAME_STB;
    logic [9:0]       X;
    logic [8:0]       Y;
    logic [N-1:0]     MOLE_MASK;
    logic             HIT_VALID;
    logic [IDX_W-1:0] HIT_IDX;
`ifdef MOLE_CURSOR_EN
    logic [IDX_W-1:0] CURSOR_IDX;
`endif
    logic [3:0]       VGA_R;
    logic [3:0]       VGA_G;
    logic [3:0]       VGA_B;
    logic             HIT_OK;
    logic             HIT_MISS;

    modport master (
`ifdef MOLE_CURSOR_EN
        output CURSOR_IDX,
`endif
        output PIX_STB, FRAME_STB, X, Y, MOLE_MASK, HIT_VALID, HIT_IDX,
        input  VGA_R, VGA_G, VGA_B, HIT_OK, HIT_MISS
    );

    modport slave (
`ifdef MOLE_CURSOR_EN
        input  CURSOR_IDX,
`endif
        input  PIX_STB, FRAME_STB, X, Y, MOLE_MASK, HIT_VALID, HIT_IDX,
        output VGA_R, VGA_G, VGA_B, HIT_OK, HIT_MISS
    );
endinterface

// File: rtl/mole_grid_renderer.sv
// mole_grid_renderer: ROWS x COLS whack-a-mole board renderer between vga640x480 timing and the VGA pins.
// Define MOLE_CURSOR_EN to add the CURSOR_IDX input and a 4-px blue border inside the selected cell.
module mole_grid_renderer #(
    parameter int unsigned ROWS         = 3,
    parameter int unsigned COLS         = 3,
    parameter int unsigned ORIGIN_X     = 100,
    parameter int unsigned ORIGIN_Y     = 60,
    parameter int unsigned CELL_W       = 80,
    parameter int unsigned CELL_H       = 80,
    parameter int unsigned PITCH_X      = 180,
    parameter int unsigned PITCH_Y      = 140,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                CLK,
    input  logic                RST_BTN,
    mole_grid_renderer_if.slave bus
);
    localparam int unsigned N        = ROWS * COLS;
    localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BOARD_X1 = ORIGIN_X + (COLS - 1) * PITCH_X + CELL_W;
    localparam int unsigned BOARD_Y1 = ORIGIN_Y + (ROWS - 1) * PITCH_Y + CELL_H;

    logic [N-1:0]  shadow_q, shadow_d;
    logic [7:0]    flash_q [N];
    logic [7:0]    flash_d [N];
    logic [11:0]   rgb_q, pix_rgb;
    logic          hit_ok_q, hit_ok_d;
    logic          hit_miss_q, hit_miss_d;
    logic          hit_sel;

    int unsigned   px, py;
    int unsigned   col_sel, row_sel, cell_sel;
    logic          on_board, col_hit, row_hit;
    logic          cell_shadow;
    logic [7:0]    cell_flash;

    // Pixel decode: board extent, then which column/row window (if any) the pixel falls in.
    always_comb begin
        px       = 32'(bus.X);
        py       = 32'(bus.Y);
        on_board = (px >= ORIGIN_X) && (px < BOARD_X1) && (py >= ORIGIN_Y) && (py < BOARD_Y1);
        col_hit  = 1'b0;
        col_sel  = 0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (px >= ORIGIN_X + c * PITCH_X && px < ORIGIN_X + c * PITCH_X + CELL_W) begin
                col_hit = 1'b1;
                col_sel = c;
            end
        end
        row_hit = 1'b0;
        row_sel = 0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (py >= ORIGIN_Y + r * PITCH_Y && py < ORIGIN_Y + r * PITCH_Y + CELL_H) begin
                row_hit = 1'b1;
                row_sel = r;
            end
        end
        cell_sel    = row_sel * COLS + col_sel;
        cell_shadow = 1'b0;
        cell_flash  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i == cell_sel) begin
                cell_shadow = shadow_q[i];
                cell_flash  = flash_q[i];
            end
        end
    end

`ifdef MOLE_CURSOR_EN
    localparam int unsigned BORDER = 4;
    logic        cursor_on;
    int unsigned x_off, y_off;

    // Offsets are only meaningful when the pixel is inside a cell; out-of-range CURSOR_IDX never matches.
    always_comb begin
        x_off     = px - (ORIGIN_X + col_sel * PITCH_X);
        y_off     = py - (ORIGIN_Y + row_sel * PITCH_Y);
        cursor_on = (32'(bus.CURSOR_IDX) == cell_sel) &&
                    ((x_off < BORDER) || (x_off >= CELL_W - BORDER) ||
                     (y_off < BORDER) || (y_off >= CELL_H - BORDER));
    end
`endif

    always_comb begin
        pix_rgb = 12'h000;
        if (on_board) begin
            if (col_hit && row_hit) begin
                if (cell_flash != 8'd0) begin
                    pix_rgb = 12'hFFF;
`ifdef MOLE_CURSOR_EN
                end else if (cursor_on) begin
                    pix_rgb = 12'h00F;
`endif
                end else if (cell_shadow) begin
                    pix_rgb = 12'h0F0;
                end
            end else begin
                pix_rgb = 12'h800;
            end
        end
    end

    // Strikes score against the pre-load shadow; a landed hit clears its bit after any frame load.
    always_comb begin
        hit_sel = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.HIT_IDX == IDX_W'(i)) begin
                hit_sel = shadow_q[i];
            end
        end
        hit_ok_d   = bus.HIT_VALID && hit_sel;
        hit_miss_d = bus.HIT_VALID && !hit_sel;
        shadow_d   = bus.FRAME_STB ? bus.MOLE_MASK : shadow_q;
        for (int unsigned i = 0; i < N; i++) begin
            flash_d[i] = flash_q[i];
            if (bus.FRAME_STB && flash_q[i] != 8'd0) begin
                flash_d[i] = flash_q[i] - 8'd1;
            end
            if (hit_ok_d && bus.HIT_IDX == IDX_W'(i)) begin
                shadow_d[i] = 1'b0;
                flash_d[i]  = 8'(FLASH_FRAMES);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            shadow_q   <= '0;
            rgb_q      <= '0;
            hit_ok_q   <= 1'b0;
            hit_miss_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                flash_q[i] <= '0;
            end
        end else begin
            shadow_q   <= shadow_d;
            hit_ok_q   <= hit_ok_d;
            hit_miss_q <= hit_miss_d;
            for (int unsigned i = 0; i < N; i++) begin
                flash_q[i] <= flash_d[i];
            end
            if (bus.PIX_STB) begin
                rgb_q <= pix_rgb;
            end
        end
    end

    assign bus.VGA_R    = rgb_q[11:8];
    assign bus.VGA_G    = rgb_q[7:4];
    assign bus.VGA_B    = rgb_q[3:0];
    assign bus.HIT_OK   = hit_ok_q;
    assign bus.HIT_MISS = hit_miss_q;
endmodule

// File: tb/tb_mole_grid_renderer.sv
// Bench for mole_grid_renderer: default 3x3 board plus a 4x4 board (pitch 100/90); cursor checks
// follow MOLE_CURSOR_EN.
module tb_mole_grid_renderer;
    localparam logic [11:0] C_OFF = 12'h000;
    localparam logic [11:0] C_WHT = 12'hFFF;
    localparam logic [11:0] C_GRN = 12'h0F0;
    localparam logic [11:0] C_BRD = 12'h800;
`ifdef MOLE_CURSOR_EN
    localparam logic [11:0] C_CUR  = 12'h00F;
    localparam logic [11:0] C_CUR0 = 12'h00F;
`else
    localparam logic [11:0] C_CUR  = 12'h0F0;
    localparam logic [11:0] C_CUR0 = 12'h000;
`endif

    typedef struct { int x; int y; logic [11:0] exp; } pix_vec_t;
    typedef struct { int which; int x; int y; logic [11:0] exp; } pix_exp_t;
    typedef struct { int which; int idx; logic [1:0] exp; } hit_exp_t;

    logic CLK = 1'b0;
    logic RST_BTN = 1'b0;
    int   total = 0;
    int   bad = 0;

    pix_exp_t pix_q[$];
    hit_exp_t hit_q[$];
    pix_vec_t latch_tbl [12];
    pix_vec_t grid4_tbl [11];

    mole_grid_renderer_if #(.N(9),  .IDX_W(4)) b3 ();
    mole_grid_renderer_if #(.N(16), .IDX_W(4)) b4 ();

    mole_grid_renderer u_dut3 (
        .CLK     (CLK),
        .RST_BTN (RST_BTN),
        .bus     (b3)
    );

    mole_grid_renderer #(
        .ROWS    (4),
        .COLS    (4),
        .PITCH_X (100),
        .PITCH_Y (90)
    ) u_dut4 (
        .CLK     (CLK),
        .RST_BTN (RST_BTN),
        .bus     (b4)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] rgb(input int which);
        if (which == 0) return {b3.VGA_R, b3.VGA_G, b3.VGA_B};
        return {b4.VGA_R, b4.VGA_G, b4.VGA_B};
    endfunction

    function automatic logic [1:0] hitout(input int which);
        if (which == 0) return {b3.HIT_OK, b3.HIT_MISS};
        return {b4.HIT_OK, b4.HIT_MISS};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_pix(input int which, input logic stb, input int x, input int y);
        if (which == 0) begin
            b3.PIX_STB = stb; b3.X = 10'(x); b3.Y = 9'(y);
        end else begin
            b4.PIX_STB = stb; b4.X = 10'(x); b4.Y = 9'(y);
        end
    endtask

    task automatic set_frame(input int which, input logic stb, input logic [15:0] mask);
        if (which == 0) begin
            b3.FRAME_STB = stb; b3.MOLE_MASK = mask[8:0];
        end else begin
            b4.FRAME_STB = stb; b4.MOLE_MASK = mask;
        end
    endtask

    task automatic set_hit(input int which, input logic v, input int idx);
        if (which == 0) begin
            b3.HIT_VALID = v; b3.HIT_IDX = 4'(idx);
        end else begin
            b4.HIT_VALID = v; b4.HIT_IDX = 4'(idx);
        end
    endtask

    task automatic pix_push(input int which, input int x, input int y, input logic [11:0] exp);
        set_pix(which, 1'b1, x, y);
        pix_q.push_back('{which, x, y, exp});
    endtask

    task automatic pix_pop();
        pix_exp_t e;
        e = pix_q.pop_front();
        check($sformatf("pix%0d(%0d,%0d)", e.which, e.x, e.y), 16'(rgb(e.which)), 16'(e.exp));
    endtask

    task automatic pix(input int which, input int x, input int y, input logic [11:0] exp);
        pix_push(which, x, y, exp);
        step();
        set_pix(which, 1'b0, x, y);
        pix_pop();
    endtask

    task automatic frame(input int which, input logic [15:0] mask);
        set_frame(which, 1'b1, mask);
        step();
        set_frame(which, 1'b0, mask);
    endtask

    // Drives one strike (optionally alongside a FRAME_STB set up by the caller) and checks the pulse.
    task automatic hit(input int which, input int idx, input logic exp_ok, input logic exp_miss);
        hit_exp_t e;
        set_hit(which, 1'b1, idx);
        hit_q.push_back('{which, idx, {exp_ok, exp_miss}});
        step();
        set_hit(which, 1'b0, idx);
        if (which == 0) b3.FRAME_STB = 1'b0; else b4.FRAME_STB = 1'b0;
        e = hit_q.pop_front();
        check($sformatf("hit%0d[%0d] ok/miss", e.which, e.idx), 16'(hitout(e.which)), 16'(e.exp));
        step();
        check($sformatf("hit%0d[%0d] pulse width", which, idx), 16'(hitout(which)), 16'h0);
    endtask

    initial begin
        latch_tbl = '{
            '{120,  80, C_GRN}, '{300,  80, C_OFF}, '{200,  80, C_BRD}, '{ 20,  20, C_OFF},
            '{ 99,  80, C_OFF}, '{100,  60, C_GRN}, '{179, 139, C_GRN}, '{180,  80, C_BRD},
            '{100, 140, C_BRD}, '{540,  80, C_OFF}, '{539, 419, C_OFF}, '{100,  59, C_OFF}
        };
        grid4_tbl = '{
            '{200, 160, C_CUR}, '{203, 190, C_CUR}, '{204, 190, C_GRN}, '{275, 190, C_GRN},
            '{276, 190, C_CUR}, '{279, 229, C_CUR}, '{240, 150, C_CUR}, '{240, 154, C_GRN},
            '{190, 160, C_BRD}, '{479, 409, C_OFF}, '{480, 160, C_OFF}
        };

        set_pix(0, 1'b0, 0, 0); set_pix(1, 1'b0, 0, 0);
        set_frame(0, 1'b1, 16'h01FF); set_frame(1, 1'b1, 16'hFFFF);
        set_hit(0, 1'b1, 0); set_hit(1, 1'b1, 0);
`ifdef MOLE_CURSOR_EN
        b3.CURSOR_IDX = 4'd9;
        b4.CURSOR_IDX = 4'd5;
`endif
        // Reset held 3 clocks with strobes toggling and frame/hit requests pending.
        RST_BTN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_pix(0, (k % 2) == 0, 120, 80);
            set_pix(1, (k % 2) == 0, 240, 190);
            step();
        end
        check("reset rgb3", 16'(rgb(0)), 16'h0);
        check("reset rgb4", 16'(rgb(1)), 16'h0);
        check("reset hit3", 16'(hitout(0)), 16'h0);
        check("reset hit4", 16'(hitout(1)), 16'h0);
        set_frame(0, 1'b0, 16'h0); set_frame(1, 1'b0, 16'h0);
        set_hit(0, 1'b0, 0); set_hit(1, 1'b0, 0);
        set_pix(0, 1'b0, 120, 80); set_pix(1, 1'b0, 240, 190);
        RST_BTN = 1'b1;
        pix(0, 120, 80, C_OFF);
        pix(0, 300, 220, C_OFF);

        // Frame latch with mid-frame mask change, back-to-back pixel strobes.
        frame(0, 16'h0001);
        set_frame(0, 1'b0, 16'h01FF);
        for (int i = 0; i < 12; i++) begin
            pix_push(0, latch_tbl[i].x, latch_tbl[i].y, latch_tbl[i].exp);
            step();
            pix_pop();
        end
        set_pix(0, 1'b0, 120, 80);
        step();
        check("hold while PIX_STB low", 16'(rgb(0)), 16'(C_OFF));
        frame(0, 16'h01FF);
        pix(0, 539, 419, C_GRN);
        pix(0, 300, 80, C_GRN);

        // Hit and 8-frame flash on cell 4.
        frame(0, 16'h0010);
        hit(0, 4, 1'b1, 1'b0);
        hit(0, 4, 1'b0, 1'b1);
        pix(0, 300, 220, C_WHT);
        for (int k = 1; k <= 7; k++) begin
            frame(0, 16'h0000);
            pix(0, 300, 220, C_WHT);
        end
        frame(0, 16'h0000);
        pix(0, 300, 220, C_OFF);
        hit(0, 4, 1'b0, 1'b1);

        // Counter reloads on a second landed hit while still flashing.
        frame(0, 16'h0010);
        hit(0, 4, 1'b1, 1'b0);
        frame(0, 16'h0010);
        frame(0, 16'h0010);
        hit(0, 4, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) frame(0, 16'h0000);
        pix(0, 300, 220, C_WHT);
        frame(0, 16'h0000);
        pix(0, 300, 220, C_OFF);

        // Misses: out-of-range and empty cells leave state alone.
        frame(0, 16'h0100);
        hit(0, 9, 1'b0, 1'b1);
        hit(0, 15, 1'b0, 1'b1);
        pix(0, 500, 380, C_GRN);
        hit(0, 0, 1'b0, 1'b1);
        pix(0, 120, 80, C_OFF);

        // FRAME_STB and HIT_VALID in the same cycle, with cell 4 still counting down.
        frame(0, 16'h0000);
        frame(0, 16'h0010);
        hit(0, 4, 1'b1, 1'b0);
        frame(0, 16'h0000);
        set_frame(0, 1'b1, 16'h0001);
        hit(0, 0, 1'b0, 1'b1);
        pix(0, 120, 80, C_GRN);
        set_frame(0, 1'b1, 16'h0001);
        hit(0, 0, 1'b1, 1'b0);
        hit(0, 0, 1'b0, 1'b1);
        pix(0, 120, 80, C_WHT);
        pix(0, 300, 220, C_WHT);
        for (int k = 1; k <= 5; k++) frame(0, 16'h0000);
        pix(0, 300, 220, C_OFF);
        pix(0, 120, 80, C_WHT);
        frame(0, 16'h0000);
        frame(0, 16'h0000);
        pix(0, 120, 80, C_WHT);
        frame(0, 16'h0000);
        pix(0, 120, 80, C_OFF);

        // Reset in the middle of a flash clears everything; frames resume afterwards.
        frame(0, 16'h0011);
        hit(0, 4, 1'b1, 1'b0);
        RST_BTN = 1'b0;
        step();
        RST_BTN = 1'b1;
        pix(0, 120, 80, C_OFF);
        pix(0, 300, 220, C_OFF);
        frame(0, 16'h0001);
        pix(0, 120, 80, C_GRN);

        // 4x4 board, cell 5 occupied; cursor border when enabled.
        frame(1, 16'h0020);
        for (int i = 0; i < 11; i++) begin
            pix_push(1, grid4_tbl[i].x, grid4_tbl[i].y, grid4_tbl[i].exp);
            step();
            pix_pop();
        end
        set_pix(1, 1'b0, 0, 0);
        hit(1, 5, 1'b1, 1'b0);
        pix(1, 200, 160, C_WHT);
        pix(1, 240, 190, C_WHT);
        for (int k = 1; k <= 8; k++) frame(1, 16'h0000);
        pix(1, 200, 160, C_CUR0);
        pix(1, 240, 190, C_OFF);
        hit(1, 15, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
